// File: rtl/example_arbiter.sv
// Round-robin arbiter sharing one datapath between N requesters; grants are capped
// at HOLD consecutive cycles and the winner's operands are steered onto a/b.
module example_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned HOLD  = 3,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     a_in,
    input  logic [N-1:0]     b_in,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] owner,
    output logic             busy,
    output logic             preempt,
    output logic             a,
    output logic             b
);

    localparam int unsigned CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(HOLD - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               preempt_q, preempt_d;

    logic               found;
    logic [IDX_W-1:0]   win;
    logic [IDX_W-1:0]   idx_b;
    int unsigned        idx;
    logic               keep;
    logic               expired;

    // First set request scanning upward from ptr_q, wrapping modulo N.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        idx_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx   = (32'(ptr_q) + i) % N;
            idx_b = IDX_W'(idx);
            if (!found && req[idx_b]) begin
                found = 1'b1;
                win   = idx_b;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        keep      = req[owner_q];
        expired   = (cnt_q == CntMax);

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StGrant;
                    gnt_d   = N'(1) << win;
                    owner_d = win;
                    ptr_d   = IDX_W'((32'(win) + 1) % N);
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                preempt_d = keep && expired;
                if (keep && !expired) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (found) begin
                    // Back-to-back handover; may re-grant the same owner after a wrap.
                    gnt_d   = N'(1) << win;
                    owner_d = win;
                    ptr_d   = IDX_W'((32'(win) + 1) % N);
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign gnt     = gnt_q;
    assign owner   = owner_q;
    assign busy    = (state_q == StGrant);
    assign preempt = preempt_q;
    assign a       = busy ? a_in[owner_q] : 1'b0;
    assign b       = busy ? b_in[owner_q] : 1'b0;

endmodule

// File: tb/tb_example_arbiter.sv
// Scoreboarded bench for example_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural round-robin model.
module tb_example_arbiter;

    localparam int N     = 4;
    localparam int HOLD  = 3;
    localparam int IDX_W = $clog2(N);

    logic             clk = 1'b0;
    logic             rstn;
    logic [N-1:0]     req, a_in, b_in, gnt;
    logic [IDX_W-1:0] owner;
    logic             busy, preempt, a, b;

    always #5 clk = ~clk;

    example_arbiter #(.N(N), .HOLD(HOLD)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .preempt (preempt),
        .a       (a),
        .b       (b)
    );

    typedef struct {
        logic [N-1:0] gnt;
        int           owner;
        bit           busy;
        bit           pre;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: who holds the grant, for how long, and where the next search starts.
    bit m_busy;
    int m_owner, m_ptr, m_used;
    bit m_pre;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_used = 0; m_pre = 0;
    endfunction

    function automatic int rr_pick(logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (m_ptr + i) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    function automatic void model_edge(logic [N-1:0] r);
        int  w;
        bit  hand_over;
        m_pre = 0;
        hand_over = !m_busy;
        if (m_busy) begin
            m_used++;
            if (r[m_owner] && m_used == HOLD) m_pre = 1;
            hand_over = !r[m_owner] || m_used == HOLD;
        end
        if (hand_over) begin
            w = rr_pick(r);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_ptr = (w + 1) % N; m_used = 0;
            end else begin
                m_busy = 0;
            end
        end
    endfunction

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] ra, input logic [N-1:0] rb);
        exp_t x;
        req = r; a_in = ra; b_in = rb;
        @(posedge clk);
        model_edge(req);
        x.gnt = m_busy ? N'(1 << m_owner) : '0;
        x.owner = m_owner;
        x.busy = m_busy;
        x.pre = m_pre;
        q.push_back(x);
        #1;
    endtask

    always @(negedge clk) begin
        if (rstn && q.size() > 0) begin
            e = q.pop_front();
            check("sb_gnt", 32'(gnt), 32'(e.gnt));
            check("sb_owner", 32'(owner), 32'(e.owner));
            check("sb_busy", 32'(busy), 32'(e.busy));
            check("sb_preempt", 32'(preempt), 32'(e.pre));
            check("sb_a", 32'(a), e.busy ? 32'(a_in[e.owner]) : 32'd0);
            check("sb_b", 32'(b), e.busy ? 32'(b_in[e.owner]) : 32'd0);
        end
    end

    initial begin
        logic [N-1:0] r;
        rstn = 1'b0; req = '0; a_in = '1; b_in = '1;
        model_reset();
        #2;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_preempt", 32'(preempt), 32'd0);
        check("rst_a", 32'(a), 32'd0);
        check("rst_b", 32'(b), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Fairness: all requesting, each owner holds exactly HOLD cycles in order.
        for (int k = 0; k < 13; k++) begin
            step(4'b1111, 4'b0000, 4'b0000);
            check("fair_gnt", 32'(gnt), 32'(1 << ((k / 3) % 4)));
            check("fair_busy", 32'(busy), 32'd1);
        end
        step(4'b0000, 4'b0000, 4'b0000);
        check("drop_idle", 32'(busy), 32'd0);

        // Lone requester is re-granted across HOLD boundaries with preempt pulses.
        for (int k = 0; k < 7; k++) begin
            step(4'b0100, 4'b0000, 4'b0000);
            check("single_gnt", 32'(gnt), 32'h4);
            check("single_pre", 32'(preempt), (k == 3 || k == 6) ? 32'd1 : 32'd0);
        end
        step(4'b0000, 4'b0000, 4'b0000);
        check("single_fall", 32'(busy), 32'd0);

        // Early release: owner 1 drops after one cycle, owner 3 follows with no gap.
        step(4'b0001, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);
        step(4'b1010, 4'b0000, 4'b0000);
        check("early_gnt1", 32'(gnt), 32'h2);
        step(4'b1000, 4'b0000, 4'b0000);
        check("early_gnt3", 32'(gnt), 32'h8);
        check("early_pre", 32'(preempt), 32'd0);

        // Operand steering from owner 2; non-owner input changes must not leak.
        step(4'b0000, 4'b0000, 4'b0000);
        step(4'b0100, 4'b0100, 4'b1011);
        check("steer_a", 32'(a), 32'd1);
        check("steer_b", 32'(b), 32'd0);
        a_in = 4'b0101;
        #1;
        check("steer_a_iso", 32'(a), 32'd1);
        step(4'b0000, 4'b1111, 4'b1111);
        check("idle_a", 32'(a), 32'd0);
        check("idle_b", 32'(b), 32'd0);

        // Late request joins the search at the owner's release edge.
        step(4'b0010, 4'b0000, 4'b0000);
        check("late_own1", 32'(gnt), 32'h2);
        step(4'b1000, 4'b0000, 4'b0000);
        check("late_gnt3", 32'(gnt), 32'h8);
        check("late_busy", 32'(busy), 32'd1);

        // Asynchronous reset mid-grant, then restart from index 0.
        step(4'b0100, 4'b1111, 4'b1111);
        check("pre_rst_gnt", 32'(gnt), 32'h4);
        #2;
        rstn = 1'b0;
        q.delete();
        model_reset();
        #1;
        check("async_gnt", 32'(gnt), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_a", 32'(a), 32'd0);
        check("async_b", 32'(b), 32'd0);
        check("async_owner", 32'(owner), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step(4'b1111, 4'b0000, 4'b0000);
        check("post_rst_gnt", 32'(gnt), 32'h1);

        // Randomized traffic; requests often persist to exercise HOLD expiry.
        r = 4'b0000;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom);
            step(r, N'($urandom), N'($urandom));
        end
        step(4'b0000, 4'b0000, 4'b0000);

        @(negedge clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
